// File: rtl/imem_boot_loader_if.sv
// Boot loader bus: byte stream in, instruction-memory write port and status out.
// master = stream source / memory side, slave = the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;
  logic [15:0]           word_count;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_reset, load_done, load_error, word_count
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output cpu_reset, load_done, load_error, word_count
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte stream -> little-endian 32-bit words -> imem write port.
// Optional trailing mod-256 payload checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input logic              clk,
  input logic              reset,
  imem_boot_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
`endif

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] word_idx;
  logic [31:0] asm_word;
  logic [15:0] len;
  logic        accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign bus.rx_ready = !reset && (state != DONE) && (state != ERROR);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign len          = {bus.rx_data, bus.word_count[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= LEN_LO;
      byte_cnt       <= '0;
      word_idx       <= '0;
      asm_word       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_reset  <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
      bus.word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      bus.imem_we   <= 1'b0;
      // Released only after a full cycle in DONE, so the last write has landed.
      bus.cpu_reset <= (state != DONE);
      unique case (state)
        LEN_LO: if (accept) begin
          bus.word_count[7:0] <= bus.rx_data;
          state               <= LEN_HI;
        end
        LEN_HI: if (accept) begin
          bus.word_count[15:8] <= bus.rx_data;
          if ({1'b0, len} > MAX_N) begin
            state          <= ERROR;
            bus.load_error <= 1'b1;
          end else if (len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state         <= DONE;
            bus.load_done <= 1'b1;
`endif
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          // Shift in from the top: after four bytes byte 0 sits in bits 7:0.
          asm_word <= {bus.rx_data, asm_word[31:8]};
          byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum      <= sum + bus.rx_data;
`endif
          if (byte_cnt == 2'd3) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= word_idx[ADDR_WIDTH-1:0];
            bus.imem_wdata <= {bus.rx_data, asm_word[31:8]};
            word_idx       <= word_idx + 16'd1;
            if (word_idx == bus.word_count - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state         <= DONE;
              bus.load_done <= 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (accept) begin
          if (bus.rx_data == sum) begin
            state         <= DONE;
            bus.load_done <= 1'b1;
          end else begin
            state          <= ERROR;
            bus.load_error <= 1'b1;
          end
        end
`endif
        DONE:    ;
        ERROR:   ;
        default: state <= LEN_LO;
      endcase
    end
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Serial-to-instruction-memory boot loader that sits directly upstream of the RISCV core. It accepts a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory write port. It holds the core in reset until the image is fully loaded, then releases it.

## Interface

- ADDR_WIDTH, 8, instruction memory word-address width
- MAX_WORDS, 256, largest accepted image in words; must be ≤ 2^ADDR_WIDTH
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  incoming stream byte
- rx_valid  input  1  rx_data is valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle (combinational from state)
- imem_we  output  1  one-cycle instruction memory write strobe
- imem_addr  output  ADDR_WIDTH  word address of the write
- imem_wdata  output  32  instruction word to write
- cpu_reset  output  1  drives the core's reset; high until the load completes
- load_done  output  1  image loaded successfully
- load_error  output  1  image rejected
- word_count  output  16  latched image length N

## Operation

- Stream format: N low byte, N high byte, then 4·N payload bytes, each word little-endian (byte 0 = bits 7:0).
- A byte is accepted on a rising edge where rx_valid && rx_ready. At most one byte per cycle; back-to-back acceptance is required.
- States: LEN_LO → LEN_HI → DATA → (CHECK) → DONE; ERROR is terminal.
  - LEN_LO: accept the byte into word_count[7:0].
  - LEN_HI: accept the byte into word_count[15:8]. If N > MAX_WORDS → ERROR. If N = 0 → CHECK when the macro is defined, otherwise DONE. Else → DATA.
  - DATA: shift the byte into the assembly register and increment the 2-bit byte counter. On the 4th byte, issue a write to word index w (0-based) and increment w. After word N−1 → CHECK/DONE.
  - DONE: rx_ready = 0, load_done = 1, cpu_reset = 0. Held until reset.
  - ERROR: rx_ready = 0, load_error = 1, cpu_reset = 1, no further writes. Held until reset.
- rx_ready = 1 in LEN_LO, LEN_HI, DATA, and CHECK. It is forced to 0 while reset is high.
- Partial words are never written.

## Timing

- Reset values: state LEN_LO, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, load_done 0, load_error 0, word_count 0; byte and word counters 0.
- Write latency: the edge that accepts the 4th byte of word w registers imem_we = 1, imem_addr = w, and imem_wdata. These are visible for exactly one cycle, and memory captures them on the next edge.
- cpu_reset is registered from state. It falls one cycle after DONE is entered, which is the same edge on which memory captures the last word, so the core never fetches an unwritten word.
- load_done rises in the first cycle in DONE. load_error rises in the first cycle in ERROR.
- Reset asserted mid-load (any state) returns to the reset values on the next edge. Partially assembled bytes are discarded and memory contents are left untouched.
- word_count holds its value through DONE and ERROR.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - After the payload (or immediately after LEN_HI when N = 0), the CHECK state accepts one byte.
  - This byte must equal the mod-256 sum of all payload bytes; length bytes are excluded.
  - Match → DONE. Mismatch → ERROR.
  - Writes already issued remain in memory, and cpu_reset stays high.
- LOADER_CHECKSUM_EN undefined: there is no CHECK state and no running sum logic. The last payload byte, or N = 0, leads directly to DONE.

## Test plan

- Basic load: bytes 02 00 93 00 50 00 33 81 10 00 sent back-to-back → writes addr 0 = 0x00500093 and addr 1 = 0x00108133, each one cycle. Then load_done = 1, cpu_reset falls one cycle after DONE, and word_count = 2. With the macro defined, append byte A7.
- Throttled source: the same stream with 0–3 idle cycles of rx_valid = 0 between bytes → identical writes and values. rx_ready stays high until DONE.
- Empty image: 00 00 (plus 00 with the macro defined) → no imem_we pulses, load_done = 1, cpu_reset = 0.
- Oversize: 01 01 (N = 257, default MAX_WORDS) → ERROR, load_error = 1, rx_ready = 0, cpu_reset stays 1, and no writes even though payload bytes continue arriving.
- Reset mid-word: after 02 00 93 00, assert reset for one cycle, then send the full basic stream → no write from the aborted word. The writes match the basic-load case.
- Checksum mismatch (macro defined): basic stream with trailer A6 → two writes occur, then ERROR, load_error = 1, cpu_reset stays 1.
